// File: rtl/rf_wb_queue_if.sv
// Bundle of producer, drain and forwarding signals for the write-back queue.
// The master side is the environment: it drives the producers and lookup
// addresses. The slave side is the queue.
interface rf_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          p0_valid;
    logic          p0_ready;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_data;

    logic          p1_valid;
    logic          p1_ready;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_data;

    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;

    logic [AW-1:0] fa1;
    logic [AW-1:0] fa2;
    logic          fhit1;
    logic          fhit2;
    logic [DW-1:0] fdata1;
    logic [DW-1:0] fdata2;

    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport master (
        output p0_valid, p0_addr, p0_data,
        output p1_valid, p1_addr, p1_data,
        output fa1, fa2,
        input  p0_ready, p1_ready,
        input  we3, wa3, wd3,
        input  fhit1, fhit2, fdata1, fdata2,
        input  count, empty, full
    );

    modport slave (
        input  p0_valid, p0_addr, p0_data,
        input  p1_valid, p1_addr, p1_data,
        input  fa1, fa2,
        output p0_ready, p1_ready,
        output we3, wa3, wd3,
        output fhit1, fhit2, fdata1, fdata2,
        output count, empty, full
    );
endinterface

// File: rtl/rf_wb_queue.sv
// Register-file write-back queue. Two producers enqueue writes, and the queue
// drains one entry per cycle into the register-file write port. Pending writes
// are forwarded to the two read ports so that readers see the youngest value.
// A write to register 0 completes its handshake but is never stored.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic          clk,
    input logic          rst_n,
    rf_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] tail_p0;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] free;
    logic [CW-1:0] p1_need;
    logic          pop;
    logic          p0_live;
    logic          p0_rdy;
    logic          p1_rdy;
    logic          st_p0;
    logic          st_p1;

    logic [PW-1:0] fidx;
    logic          fhit1, fhit2;
    logic [DW-1:0] fdata1, fdata2;

    // Drain whenever occupied; the slot freed by this cycle's pop counts as
    // free space, so a full queue still accepts one entry per cycle.
    // A register-0 p0 request holds no slot, so it does not reserve space
    // ahead of p1.
    always_comb begin
        pop     = (count_q != '0);
        free    = DEPTH_C - count_q + CW'(pop);
        p0_live = bus.p0_valid && (bus.p0_addr != '0);
        p1_need = p0_live ? CW'(2) : CW'(1);
        p0_rdy  = (free >= CW'(1));
        p1_rdy  = (free >= p1_need);
        st_p0   = p0_live && p0_rdy;
        st_p1   = bus.p1_valid && p1_rdy && (bus.p1_addr != '0);
    end

    // Enqueue p1 ahead of p0. The long-latency result belongs to the older
    // instruction, so p0's value must commit last.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        tail_p0 = tail_q + PW'(st_p1);
        if (st_p1) begin
            mem_d[tail_q] = '{addr: bus.p1_addr, data: bus.p1_data};
        end
        if (st_p0) begin
            mem_d[tail_p0] = '{addr: bus.p0_addr, data: bus.p0_data};
        end
        tail_d  = tail_q + PW'(st_p0) + PW'(st_p1);
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(st_p0) + CW'(st_p1) - CW'(pop);
    end

    // Forwarding: scan the entries from oldest to youngest so that the last
    // match found is the youngest pending write.
    always_comb begin
        fhit1  = 1'b0;
        fhit2  = 1'b0;
        fdata1 = '0;
        fdata2 = '0;
        fidx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((bus.fa1 != '0) && (mem_q[fidx].addr == bus.fa1)) begin
                    fhit1  = 1'b1;
                    fdata1 = mem_q[fidx].data;
                end
                if ((bus.fa2 != '0) && (mem_q[fidx].addr == bus.fa2)) begin
                    fhit2  = 1'b1;
                    fdata2 = mem_q[fidx].data;
                end
            end
        end
    end

    assign bus.p0_ready = p0_rdy;
    assign bus.p1_ready = p1_rdy;
    assign bus.we3      = pop;
    assign bus.wa3      = pop ? mem_q[head_q].addr : '0;
    assign bus.wd3      = pop ? mem_q[head_q].data : '0;
    assign bus.fhit1    = fhit1;
    assign bus.fhit2    = fhit2;
    assign bus.fdata1   = fdata1;
    assign bus.fdata2   = fdata2;
    assign bus.count    = count_q;
    assign bus.empty    = (count_q == '0);
    assign bus.full     = (count_q == DEPTH_C);

    // State register. Reset discards all pending entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue. Stimulus pushes the expected commits in
// acceptance order, and a negedge monitor pops and compares every commit.
module tb_rf_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   mcount;
    bit   mon_en;
    bit   pend0, pend1, acc1;
    ent_t pe0, pe1;
    ent_t sb[$];

    rf_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Commit monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.we3 === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL commit_unexpected actual wa3=%0h wd3=%0h required no commit",
                             bus.wa3, bus.wd3);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("commit_wa3", 32'(bus.wa3), 32'(e.a));
                    chk("commit_wd3", bus.wd3, e.d);
                end
            end else begin
                chk("idle_we3", 32'(bus.we3), 32'd0);
                chk("idle_wa3_wd3", 32'(bus.wa3) | bus.wd3, 32'd0);
            end
        end
    end

    // Drive one cycle of requests (called just after a posedge), then check the
    // handshake and status outputs at the following negedge against the model.
    task automatic issue(input logic p0v, input logic [AW-1:0] p0a, input logic [DW-1:0] p0d,
                         input logic p1v, input logic [AW-1:0] p1a, input logic [DW-1:0] p1d);
        int  mfree;
        bit  mpop, p0live, e0r, e1r;
        bus.p0_valid = p0v;
        bus.p0_addr  = p0a;
        bus.p0_data  = p0d;
        bus.p1_valid = p1v;
        bus.p1_addr  = p1a;
        bus.p1_data  = p1d;
        @(negedge clk);
        mpop   = (mcount > 0);
        mfree  = DEPTH - mcount + int'(mpop);
        p0live = p0v && (p0a != 0);
        e0r    = (mfree >= 1);
        e1r    = (mfree >= (p0live ? 2 : 1));
        chk("p0_ready", 32'(bus.p0_ready), 32'(e0r));
        chk("p1_ready", 32'(bus.p1_ready), 32'(e1r));
        chk("count", 32'(bus.count), 32'(mcount));
        chk("empty", 32'(bus.empty), 32'(mcount == 0));
        chk("full", 32'(bus.full), 32'(mcount == DEPTH));
        pend0 = p0live && e0r;
        pend1 = p1v && e1r && (p1a != 0);
        acc1  = p1v && e1r;
        pe0   = '{a: p0a, d: p0d};
        pe1   = '{a: p1a, d: p1d};
    endtask

    task automatic tick();
        bit mpop;
        @(posedge clk);
        mpop = (mcount > 0);
        if (pend1) sb.push_back(pe1);
        if (pend0) sb.push_back(pe0);
        mcount = mcount + int'(pend0) + int'(pend1) - int'(mpop);
        pend0 = 1'b0;
        pend1 = 1'b0;
        #1;
    endtask

    task automatic idle_cycle();
        issue(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
    endtask

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
        return (a == 5'd31) ? 5'd1 : a + 5'd1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] na, a0, a1;
        logic [DW-1:0] d0, d1;
        bit p1_have;
        checks   = 0;
        failures = 0;
        mcount   = 0;
        mon_en   = 1'b0;
        pend0    = 1'b0;
        pend1    = 1'b0;

        // Reset with both producers requesting
        rst_n        = 1'b0;
        bus.p0_valid = 1'b1;
        bus.p0_addr  = 5'd5;
        bus.p0_data  = 32'h1111_1111;
        bus.p1_valid = 1'b1;
        bus.p1_addr  = 5'd6;
        bus.p1_data  = 32'h2222_2222;
        bus.fa1      = 5'd5;
        bus.fa2      = 5'd6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we3", 32'(bus.we3), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_p0_ready", 32'(bus.p0_ready), 32'd1);
        chk("rst_p1_ready", 32'(bus.p1_ready), 32'd1);
        chk("rst_fhit1", 32'(bus.fhit1), 32'd0);
        rst_n        = 1'b1;
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single write r5 = 0x1234
        bus.fa1 = 5'd5;
        bus.fa2 = 5'd0;
        issue(1'b1, 5'd5, 32'h0000_1234, 1'b0, '0, '0);
        tick();
        issue(1'b0, '0, '0, 1'b0, '0, '0);
        chk("single_we3", 32'(bus.we3), 32'd1);
        chk("single_fhit1", 32'(bus.fhit1), 32'd1);
        chk("single_fdata1", bus.fdata1, 32'h0000_1234);
        tick();
        issue(1'b0, '0, '0, 1'b0, '0, '0);
        chk("single_after_we3", 32'(bus.we3), 32'd0);
        chk("single_after_fhit1", 32'(bus.fhit1), 32'd0);
        tick();

        // Same-cycle collision on r3
        issue(1'b1, 5'd3, 32'hAAAA_0000, 1'b1, 5'd3, 32'hBBBB_0000);
        tick();
        bus.fa2 = 5'd3;
        issue(1'b0, '0, '0, 1'b0, '0, '0);
        chk("coll_count", 32'(bus.count), 32'd2);
        chk("coll_fhit2", 32'(bus.fhit2), 32'd1);
        chk("coll_fdata2", bus.fdata2, 32'hAAAA_0000);
        tick();
        idle_cycle();
        idle_cycle();

        // Zero register
        bus.fa1 = 5'd0;
        bus.fa2 = 5'd0;
        issue(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
        chk("zero_p0_ready", 32'(bus.p0_ready), 32'd1);
        tick();
        issue(1'b0, '0, '0, 1'b0, '0, '0);
        chk("zero_count", 32'(bus.count), 32'd0);
        chk("zero_we3", 32'(bus.we3), 32'd0);
        chk("zero_fhit1", 32'(bus.fhit1), 32'd0);
        tick();

        // Saturation: both producers every cycle, p1 held while not ready
        na      = 5'd1;
        p1_have = 1'b0;
        a1      = '0;
        d1      = '0;
        for (int k = 0; k < 12; k++) begin
            if (!p1_have) begin
                a1      = na;
                na      = nxt(na);
                d1      = 32'hB100_0000 | 32'(k);
                p1_have = 1'b1;
            end
            a0 = na;
            na = nxt(na);
            d0 = 32'hA000_0000 | 32'(k);
            issue(1'b1, a0, d0, 1'b1, a1, d1);
            if (acc1) p1_have = 1'b0;
            tick();
        end
        if (!p1_have) begin
            a1 = na;
            na = nxt(na);
            d1 = 32'hB1FF_0000;
        end
        // Full with an address-0 p0: p1 gets the freed slot
        issue(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, a1, d1);
        chk("sat_count", 32'(bus.count), 32'd4);
        chk("sat_full", 32'(bus.full), 32'd1);
        chk("sat_zero_p1_ready", 32'(bus.p1_ready), 32'd1);
        tick();
        for (int k = 0; k < 10 && mcount > 0; k++) idle_cycle();
        chk("sat_drained", 32'(mcount), 32'd0);

        // Reset with three entries pending
        issue(1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd8, 32'h8888_0008);
        tick();
        issue(1'b1, 5'd9, 32'h9999_0009, 1'b1, 5'd10, 32'hAAAA_000A);
        tick();
        bus.fa1 = 5'd9;
        bus.fa2 = 5'd10;
        issue(1'b0, '0, '0, 1'b0, '0, '0);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        rst_n = 1'b0;
        @(posedge clk);
        sb.delete();
        mcount = 0;
        pend0  = 1'b0;
        pend1  = 1'b0;
        #1;
        rst_n = 1'b1;
        issue(1'b0, '0, '0, 1'b0, '0, '0);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_we3", 32'(bus.we3), 32'd0);
        chk("midrst_fhit1", 32'(bus.fhit1), 32'd0);
        chk("midrst_fhit2", 32'(bus.fhit2), 32'd0);
        tick();
        idle_cycle();
        idle_cycle();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Write-side companion of the register file: buffers register write-backs from two producers and drains them one per cycle into the register file write port (we3/wa3/wd3).
- Producer 0 is the main pipeline; producer 1 is a long-latency unit (mult/div, load miss) with a valid/ready handshake.
- Provides read-side forwarding of pending (not yet committed) writes so readers see the newest value.

Parameters:
- DEPTH, 4, queue entries; power of 2, >= 2
- AW, 5, register address width
- DW, 32, register data width

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- p0_valid  input  1  pipeline write request
- p0_ready  output  1  queue can accept p0 this cycle
- p0_addr  input  AW  pipeline destination register
- p0_data  input  DW  pipeline write data
- p1_valid  input  1  long-latency unit write request
- p1_ready  output  1  queue can accept p1 this cycle
- p1_addr  input  AW  p1 destination register
- p1_data  input  DW  p1 write data
- we3  output  1  register file write enable
- wa3  output  AW  register file write address
- wd3  output  DW  register file write data
- fa1, fa2  input  AW each  forwarding lookup addresses (the read-port addresses)
- fhit1, fhit2  output  1 each  a pending write to faN exists
- fdata1, fdata2  output  DW each  data of the youngest pending write to faN
- count  output  $clog2(DEPTH)+1  occupied entries
- empty  output  1  count==0
- full  output  1  count==DEPTH

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n low at posedge):
  - head/tail pointers and count cleared to 0; pending entries discarded, including on reset mid-operation.
  - Outputs after reset: we3=0, wa3=0, wd3=0, empty=1, full=0, count=0, fhitN=0, fdataN=0, p0_ready=1, p1_ready=1.
- Circular FIFO storage:
  - Each entry holds {addr, data}.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Drain:
  - we3 = !empty, combinational from state; wa3/wd3 = head entry, or 0 when empty.
  - Every cycle with we3=1 the head is popped at the posedge (pop=1); the register file commits it on the same edge.
  - Latency: an entry accepted on edge N is written on edge N+1 at the earliest.
- Acceptance:
  - free = DEPTH - count + pop.
  - p0_take = p0_valid && p0_ready, with p0_ready = (free >= 1).
  - p1_ready = (free >= (p0_valid ? 2 : 1)); p0 has priority for space.
  - A handshake completes when valid && ready at the posedge.
- Address 0:
  - Handshake completes normally, but nothing is stored.
  - An address-0 p0 does not consume p1 space: it counts as p0_valid=0 in the p1_ready equation.
- Simultaneous enqueue: the p1 entry is placed ahead of the p0 entry (the long-latency result belongs to the older instruction), so p0's value commits last.
- Count update: count_next = count + stored_p0 + stored_p1 - pop. Never exceeds DEPTH and never underflows.
- Forwarding (combinational):
  - fhitN=1 iff faN!=0 and some occupied entry, head included, has addr==faN.
  - fdataN = data of the youngest matching entry; 0 when no hit.
  - Same-cycle incoming requests are not forwarded.
- Full boundary: count=DEPTH with pop=1 gives free=1, so p0 is accepted and p1 is held; count stays DEPTH.
- p1 protocol: while p1_valid=1 and p1_ready=0, the producer holds p1_addr/p1_data stable. The queue does not check this.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles with p0/p1 valid.
  - Required: we3=0, count=0, empty=1, p0_ready=1, p1_ready=1, fhit1=0.
- Single write:
  - Stimulus: p0 writes r5=0x00001234.
  - Required: next cycle we3=1, wa3=5, wd3=0x00001234 for exactly one cycle. With fa1=5 in that cycle, fhit1=1, fdata1=0x00001234. Following cycle we3=0, empty=1.
- Same-cycle collision:
  - Stimulus: p0 r3=0xAAAA0000 and p1 r3=0xBBBB0000 in the same cycle.
  - Required: count=2; fdata2 for fa2=3 is 0xAAAA0000. Commits r3=0xBBBB0000, then r3=0xAAAA0000 on consecutive cycles.
- Zero register:
  - Stimulus: p0 addr 0 data 0xFFFFFFFF; fa1=0.
  - Required: p0_ready=1, count unchanged, we3 stays 0, fhit1=0.
- Saturation (DEPTH=4):
  - Stimulus: p0 and p1 valid every cycle with distinct addrs 1..31 cycling.
  - Required: count reaches 4 and stays. p1_ready=0 whenever free<2. Every accepted write appears once on wa3/wd3 in acceptance order (p1 before p0 per cycle); none lost or duplicated.
- Reset mid-operation:
  - Stimulus: 3 entries pending, rst_n=0 for one edge.
  - Required: next cycle count=0, we3=0, fhit1=fhit2=0; pending writes never reach wa3.
